pipeline_skid_reg: RTL

Parametrised inter-stage pipeline register carrying an instruction word and its PC+4 between CPU pipeline stages (IF/ID and later stages). It replaces the single-register stall-only stage with a valid/ready handshake, a two-entry skid buffer so that back-pressure never combinationally reaches the upstream stage, a synchronous flush that inserts a bubble for branch/jump redirects, and a saturating stall counter for performance monitoring.

---
 rtl/pipeline_skid_reg.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pipeline_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, two-entry skid buffer,
// synchronous flush (bubble insertion) and a saturating stall counter.
module pipeline_skid_reg #(
  parameter int unsigned         INSTR_W     = 32,
  parameter int unsigned         PC_W        = 32,
  parameter logic [INSTR_W-1:0]  RESET_INSTR = '0,
  parameter logic [PC_W-1:0]     RESET_PC    = {{(PC_W-2){1'b1}}, 2'b00},
  parameter int unsigned         CNT_W       = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               FLUSH,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [INSTR_W-1:0] IN_INSTRUCTION,
  input  logic [PC_W-1:0]    IN_PC_INCREMENT4,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [INSTR_W-1:0] OUT_INSTRUCTION,
  output logic [PC_W-1:0]    OUT_PC_INCREMENT4,
  output logic [CNT_W-1:0]   STALL_COUNT
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MAIN_HOLD   = 2'd0,
    MAIN_IN     = 2'd1,
    MAIN_SKID   = 2'd2,
    MAIN_BUBBLE = 2'd3
  } main_sel_t;

  state_t             state_q;
  state_t             state_d;
  main_sel_t          main_sel;
  logic               skid_load;
  logic               skid_clear;
  logic               in_xfer;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;

  // Ready depends only on registered occupancy and FLUSH, never on OUT_READY.
  assign IN_READY = (state_q != ST_SKID) && !FLUSH;
  assign in_xfer  = IN_VALID && IN_READY;

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (FLUSH) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_xfer) state_d = ST_FULL;
        ST_FULL: begin
          if (in_xfer && !OUT_READY)      state_d = ST_SKID;
          else if (!in_xfer && OUT_READY) state_d = ST_EMPTY;
        end
        ST_SKID:  if (OUT_READY) state_d = ST_FULL;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Datapath controls
  always_comb begin
    main_sel   = MAIN_HOLD;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (FLUSH) begin
      main_sel   = MAIN_BUBBLE;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_xfer) main_sel = MAIN_IN;
        ST_FULL: begin
          if (in_xfer && OUT_READY) main_sel  = MAIN_IN;
          else if (in_xfer)         skid_load = 1'b1;
          else if (OUT_READY)       main_sel  = MAIN_BUBBLE;
        end
        ST_SKID: begin
          if (OUT_READY) begin
            main_sel   = MAIN_SKID;
            skid_clear = 1'b1;
          end
        end
        default: begin
          main_sel   = MAIN_BUBBLE;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  // Main entry drives the outputs directly from flops
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      OUT_VALID         <= 1'b0;
      OUT_INSTRUCTION   <= RESET_INSTR;
      OUT_PC_INCREMENT4 <= RESET_PC;
    end else begin
      OUT_VALID <= (state_d != ST_EMPTY);
      case (main_sel)
        MAIN_IN: begin
          OUT_INSTRUCTION   <= IN_INSTRUCTION;
          OUT_PC_INCREMENT4 <= IN_PC_INCREMENT4;
        end
        MAIN_SKID: begin
          OUT_INSTRUCTION   <= skid_instr;
          OUT_PC_INCREMENT4 <= skid_pc;
        end
        MAIN_BUBBLE: begin
          OUT_INSTRUCTION   <= RESET_INSTR;
          OUT_PC_INCREMENT4 <= RESET_PC;
        end
        default: begin
          OUT_INSTRUCTION   <= OUT_INSTRUCTION;
          OUT_PC_INCREMENT4 <= OUT_PC_INCREMENT4;
        end
      endcase
    end
  end

  // Skid entry
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      skid_instr <= RESET_INSTR;
      skid_pc    <= RESET_PC;
    end else if (skid_clear) begin
      skid_instr <= RESET_INSTR;
      skid_pc    <= RESET_PC;
    end else if (skid_load) begin
      skid_instr <= IN_INSTRUCTION;
      skid_pc    <= IN_PC_INCREMENT4;
    end
  end

  // Saturating stall counter; FLUSH has no effect on it
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      STALL_COUNT <= '0;
    end else if (OUT_VALID && !OUT_READY && (STALL_COUNT != {CNT_W{1'b1}})) begin
      STALL_COUNT <= STALL_COUNT + CNT_W'(1);
    end
  end

endmodule
